// File: rtl/shift_pipe_if.sv
// Operand/result bundle for the shift pipe: operand side in, result side out.
// No storage here; timing is set by whichever module takes the slave side.
// Both directions use valid/ready. oReady is the pipe's stall indication.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  // operand side
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iD;
  logic [SHW-1:0]   iShamt;
  logic [2:0]       iMode;
  logic [TAG_W-1:0] iTag;

  // result side
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oD;
  logic [TAG_W-1:0] oTag;
  logic             oZero;
  logic             oIllegal;

  // the shifter itself
  modport slave (
    input  iValid, iD, iShamt, iMode, iTag, iReady,
    output oReady, oValid, oD, oTag, oZero, oIllegal
  );

  // the issuing ALU/sequencer plus the result consumer
  modport master (
    output iValid, iD, iShamt, iMode, iTag, iReady,
    input  oReady, oValid, oD, oTag, oZero, oIllegal
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined five-mode barrel shifter (SLL/SRL/SRA/ROL/ROR) with tag, zero and illegal flags.
// Latency popcount(REG_MASK)+1 cycles from accept; one item per cycle when unstalled.
// Whole-pipe stall when the result is valid but not taken; oReady = ~stall, all registers hold.
module shift_pipe #(
  parameter int              WIDTH    = 32,
  parameter int              SHW      = $clog2(WIDTH),
  parameter logic [SHW-1:0]  REG_MASK = 'b00100,
  parameter int              TAG_W    = 4
) (
  input  logic        iClk,
  input  logic        nRst,
  shift_pipe_if.slave bus
);

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  // One in-flight operation as it moves down the mux chain.
  typedef struct packed {
    logic             vld;
    logic             ill;
    logic [2:0]       mode;
    logic [SHW-1:0]   shamt;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] dat;
  } item_t;

  // Contents of the mandatory output register.
  typedef struct packed {
    logic             vld;
    logic             zero;
    logic             ill;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] dat;
  } out_t;

  logic  stall;
  logic  xfer_in;
  item_t head;
  item_t tail;
  out_t  out_d;
  out_t  out_q;

  // A full output register that nobody takes freezes every stage at once.
  assign stall      = out_q.vld & ~bus.iReady;
  assign bus.oReady = ~stall;
  assign xfer_in    = bus.iValid & ~stall;

  // Operand capture: fields are forced to zero unless a transfer happens, so
  // idle-cycle input activity never reaches the registers and bubbles stay clean.
  always_comb begin
    head = '0;
    if (xfer_in) begin
      head.vld   = 1'b1;
      head.ill   = (bus.iMode > MODE_ROR);
      head.mode  = bus.iMode;
      head.shamt = bus.iShamt;
      head.tag   = bus.iTag;
      head.dat   = bus.iD;
    end
  end

  // Stage k moves by 2^k when shamt bit k is set; the optional register after
  // it is selected by REG_MASK[k]. Illegal modes ride through unshifted.
  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int AMT = 1 << k;

    item_t in_s;
    item_t sh_s;
    item_t out_s;

    if (k == 0) begin : g_first
      assign in_s = head;
    end else begin : g_chain
      assign in_s = g_stg[k-1].out_s;
    end

    // Mux stage: SRA fills from the current stage input's top bit.
    always_comb begin
      sh_s = in_s;
      if (in_s.shamt[k] && !in_s.ill) begin
        case (in_s.mode)
          MODE_SLL: sh_s.dat = in_s.dat << AMT;
          MODE_SRL: sh_s.dat = in_s.dat >> AMT;
          MODE_SRA: sh_s.dat = $signed(in_s.dat) >>> AMT;
          MODE_ROL: sh_s.dat = (in_s.dat << AMT) | (in_s.dat >> (WIDTH - AMT));
          MODE_ROR: sh_s.dat = (in_s.dat >> AMT) | (in_s.dat << (WIDTH - AMT));
          default:  sh_s.dat = in_s.dat;
        endcase
      end
    end

    if (REG_MASK[k]) begin : g_reg
      item_t stg_d;
      item_t stg_q;

      // Advance (items and bubbles alike) unless the pipe is stalled.
      always_comb begin
        stg_d = sh_s;
        if (stall) begin
          stg_d = stg_q;
        end
      end

      // Stage register; reset drops whatever was in flight.
      always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
          stg_q <= '0;
        end else begin
          stg_q <= stg_d;
        end
      end

      assign out_s = stg_q;
    end else begin : g_comb
      assign out_s = sh_s;
    end
  end

  assign tail = g_stg[SHW-1].out_s;

  // Mode and shift amount are fully consumed by the last mux stage.
  logic unused_tail;
  assign unused_tail = ^{tail.mode, tail.shamt};

  // Output register next state: flags only ever set alongside a valid result.
  always_comb begin
    out_d      = out_q;
    if (!stall) begin
      out_d.vld  = tail.vld;
      out_d.dat  = tail.dat;
      out_d.tag  = tail.tag;
      out_d.zero = tail.vld & (tail.dat == '0);
      out_d.ill  = tail.vld & tail.ill;
    end
  end

  // Mandatory output register.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.oValid   = out_q.vld;
  assign bus.oD       = out_q.dat;
  assign bus.oTag     = out_q.tag;
  assign bus.oZero    = out_q.zero;
  assign bus.oIllegal = out_q.ill;

  // A refused result must be presented again, unchanged, on the next cycle.
  a_stall_hold: assert property (@(posedge iClk) disable iff (!nRst)
    (bus.oValid && !bus.iReady) |=> (bus.oValid && $stable(bus.oD) && $stable(bus.oTag)));

  // Flags are meaningless without a result and must read as zero.
  a_flags_quiet: assert property (@(posedge iClk) disable iff (!nRst)
    !bus.oValid |-> (!bus.oZero && !bus.oIllegal));

endmodule

// File: tb/tb_shift_pipe.sv
// Randomised plus directed bench for shift_pipe with a queue scoreboard.
// Stimulus pushes expected results; a negedge monitor pops on each output transfer.
// iReady is shaped by a separate process (steady, scripted drop, random, held low).
module tb_shift_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  logic iClk = 1'b0;
  logic nRst = 1'b0;

  shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  shift_pipe #(.WIDTH(W), .REG_MASK(5'b00100), .TAG_W(TW)) dut (
    .iClk (iClk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  tag;
    bit          zero;
    bit          ill;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  int   n_stall = 0;
  bit   lat_en  = 0;
  int   bp_mode = 0;
  int   bp_low  = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: shift by the full amount at once, rotates via a doubled word.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input int mode);
    logic [63:0] dd;
    case (mode)
      0: return d << sh;
      1: return d >> sh;
      2: return 32'($signed(d) >>> sh);
      3: begin dd = {d, d} << sh; return dd[63:32]; end
      4: begin dd = {d, d} >> sh; return dd[31:0]; end
      default: return d;
    endcase
  endfunction

  // Present one operand from a negedge until accepted; returns on the following negedge.
  task automatic send(input logic [31:0] d, input int sh, input int mode,
                      input logic [3:0] tag, input logic [31:0] exp_d);
    exp_t e;
    int   n;
    bus.iValid = 1'b1;
    bus.iD     = d;
    bus.iShamt = sh[4:0];
    bus.iMode  = mode[2:0];
    bus.iTag   = tag;
    n = 0;
    while (!bus.oReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oReady) begin
      check("accept_timeout", {63'd0, bus.oReady}, 64'd1);
    end else begin
      e.d    = exp_d;
      e.tag  = tag;
      e.zero = (exp_d == 32'd0);
      e.ill  = (mode > 4);
      e.acc  = cyc;
      e.lat  = lat_en;
      sb.push_back(e);
    end
    @(negedge iClk);
    bus.iValid = 1'b0;
    bus.iD     = $urandom;
    bus.iShamt = 5'($urandom);
    bus.iMode  = 3'($urandom);
    bus.iTag   = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge iClk);
      n++;
    end
    repeat (3) @(negedge iClk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Downstream readiness, changed just after each rising edge.
  initial begin
    bus.iReady = 1'b1;
    forever begin
      @(posedge iClk);
      #2;
      case (bp_mode)
        1:       bus.iReady = ($urandom_range(0, 3) != 0);
        2:       bus.iReady = 1'b0;
        default: begin
          if (bp_low > 0) begin
            bus.iReady = 1'b0;
            bp_low--;
          end else begin
            bus.iReady = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: output transfers against the scoreboard, plus stall behaviour.
  logic [31:0] hold_d;
  logic [3:0]  hold_t;
  bit          held = 0;
  always @(negedge iClk) begin
    exp_t e;
    if (!nRst) begin
      held = 0;
    end else begin
      if (held && bus.oValid) begin
        check("hold_d", 64'(bus.oD), 64'(hold_d));
        check("hold_tag", 64'(bus.oTag), 64'(hold_t));
      end
      held = 0;
      if (bus.oValid && !bus.iReady) begin
        check("oready_stall", {63'd0, bus.oReady}, 64'd0);
        n_stall++;
        held   = 1;
        hold_d = bus.oD;
        hold_t = bus.oTag;
      end
      if (bus.oValid && bus.iReady) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_out", {63'd0, bus.oValid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("data", 64'(bus.oD), 64'(e.d));
          check("tag", 64'(bus.oTag), 64'(e.tag));
          check("zero", {63'd0, bus.oZero}, {63'd0, e.zero});
          check("illegal", {63'd0, bus.oIllegal}, {63'd0, e.ill});
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          out0;
    int          stall0;
    logic [31:0] d;
    int          sh;
    int          m;

    bus.iValid = 1'b0;
    bus.iD     = '0;
    bus.iShamt = '0;
    bus.iMode  = '0;
    bus.iTag   = '0;

    repeat (2) @(negedge iClk);
    check("rst_ovalid", {63'd0, bus.oValid}, 64'd0);
    check("rst_od", 64'(bus.oD), 64'd0);
    check("rst_otag", 64'(bus.oTag), 64'd0);
    check("rst_ozero", {63'd0, bus.oZero}, 64'd0);
    check("rst_oillegal", {63'd0, bus.oIllegal}, 64'd0);
    check("rst_oready", {63'd0, bus.oReady}, 64'd1);
    nRst = 1'b1;
    @(negedge iClk);

    // Directed operands, back-to-back with iReady steady.
    lat_en = 1;
    send(32'h80000000, 16, 2, 4'h1, 32'hFFFF8000);
    send(32'h80000000, 16, 1, 4'h2, 32'h00008000);
    send(32'h12345678,  8, 4, 4'h3, 32'h78123456);
    send(32'h80000001,  1, 3, 4'h4, 32'h00000003);
    send(32'h00000001, 31, 0, 4'h5, 32'h80000000);
    send(32'h7FFFFFFF, 31, 2, 4'h6, 32'h00000000);
    send(32'h80000000, 31, 2, 4'h7, 32'hFFFFFFFF);
    send(32'h00000001, 31, 4, 4'h8, 32'h00000002);
    for (int i = 0; i < 5; i++) send(32'hA5C30F96, 0, i, 4'(9 + i), 32'hA5C30F96);
    send(32'hDEADBEEF, 13, 6, 4'hE, 32'hDEADBEEF);
    drain();

    // Eight tagged items with a three-cycle iReady drop mid-stream.
    lat_en = 0;
    out0   = n_out;
    stall0 = n_stall;
    for (int i = 0; i < 8; i++) begin
      d  = $urandom;
      sh = $urandom_range(0, 31);
      m  = $urandom_range(0, 4);
      send(d, sh, m, 4'(i), ref_shift(d, sh, m));
      if (i == 3) bp_low = 3;
    end
    drain();
    check("bp_count", 64'(n_out - out0), 64'd8);
    check("bp_stall_seen", {63'd0, (n_stall > stall0)}, 64'd1);

    // Random operands, modes (illegal included) and random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      d  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      sh = $urandom_range(0, 31);
      m  = $urandom_range(0, 7);
      send(d, sh, m, 4'(i), ref_shift(d, sh, m));
      if ($urandom_range(0, 5) == 0) @(negedge iClk);
    end
    bp_mode = 0;
    drain();

    // Asynchronous reset with two items in flight.
    bp_mode = 2;
    send(32'h0000F00D, 4, 0, 4'hA, 32'h000F00D0);
    send(32'h00C0FFEE, 4, 1, 4'hB, 32'h000C0FFE);
    @(posedge iClk);
    #2;
    nRst = 1'b0;
    #1;
    check("arst_ovalid", {63'd0, bus.oValid}, 64'd0);
    check("arst_od", 64'(bus.oD), 64'd0);
    check("arst_otag", 64'(bus.oTag), 64'd0);
    check("arst_ozero", {63'd0, bus.oZero}, 64'd0);
    check("arst_oillegal", {63'd0, bus.oIllegal}, 64'd0);
    sb.delete();
    bp_mode = 0;
    repeat (2) @(negedge iClk);
    nRst = 1'b1;
    @(negedge iClk);
    out0   = n_out;
    lat_en = 1;
    send(32'h00000003, 4, 0, 4'h5, 32'h00000030);
    drain();
    repeat (4) @(negedge iClk);
    check("post_rst_count", 64'(n_out - out0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined, five-mode barrel shifter for the execute stage: logical left/right, arithmetic right, rotate left/right.
- Log2(WIDTH) mux stages; a register can optionally follow any of them.
- Valid/ready handshake with full-pipe stall carries an opaque tag, so the ALU/sequencer can issue back-to-back and match results.
- Produces a zero flag for condition codes.

Parameters:
- WIDTH, 32: data width. Power of two, 8..64.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- REG_MASK, 'b00100: SHW bits. Bit k=1 inserts a pipeline register after mux stage k (stage k shifts by 2^k).
- TAG_W, 4: width of the sideband tag carried alongside data.

Ports:
- iClk  in  1  clock, rising edge
- nRst  in  1  asynchronous active-low reset
- iValid  in  1  input operand valid
- oReady  out  1  block accepts input this cycle
- iD  in  WIDTH  operand
- iShamt  in  SHW  shift amount, unsigned
- iMode  in  3  0=SLL 1=SRL 2=SRA 3=ROL 4=ROR; 5..7 illegal
- iTag  in  TAG_W  sideband, returned unchanged
- oValid  out  1  result valid
- iReady  in  1  downstream accepts result
- oD  out  WIDTH  result
- oTag  out  TAG_W  tag of the result
- oZero  out  1  oD == 0
- oIllegal  out  1  result came from an illegal mode

Behaviour:
- One clock iClk; reset is asynchronous, active-low, on nRst.
- While nRst=0:
  - all stage valid bits clear;
  - oValid=0, oD=0, oTag=0, oZero=0, oIllegal=0.
- Reset release is synchronous to iClk. Reset mid-operation discards every in-flight item; none are replayed.
- Pipeline structure:
  - input mux stages 0..SHW-1 in ascending order;
  - a register after stage k iff REG_MASK[k];
  - one mandatory output register.
- Latency = popcount(REG_MASK)+1 cycles from the accept edge to oValid (default 2).
- Each pipeline register holds: data, remaining shamt bits, mode, tag, illegal flag, valid.
- Stall: stall = oValid & ~iReady. oReady = ~stall.
  - Transfer in: iValid & oReady. Transfer out: oValid & iReady.
  - While stalled, every pipeline register holds its contents.
  - Otherwise all registers advance; a stage with valid=0 advances as a bubble.
  - Throughput: one item per cycle when iReady is held 1.
- Bubbles are not compressed. Simultaneous in/out transfers in the same cycle are legal and required for full throughput.
- iD/iShamt/iMode/iTag are sampled only on a transfer-in edge. The block is unaffected by these inputs at any other time.
- Stage k, shamt bit k = 1 (full WIDTH result every stage):
  - SLL: shift left 2^k, zero fill.
  - SRL: shift right 2^k, zero fill.
  - SRA: shift right 2^k, fill with the current bit WIDTH-1 of the stage input.
  - ROL/ROR: bits shifted out re-enter at the opposite end.
  - Shamt bit k = 0: pass through.
- Shamt = 0 returns iD unchanged for every mode.
- Maximum shamt WIDTH-1 is valid. No saturation or modulo beyond SHW bits exists.
- Illegal mode (5..7): oD = iD unshifted, oIllegal=1. The tag still returns and the handshake is unchanged.
- oZero and oIllegal are registered with oD and valid only when oValid=1; they are held at 0 otherwise.
- oD/oTag hold stable while oValid & ~iReady.
- With REG_MASK=0, latency is 1 and the block behaves as a single output register with stall.

Test Plan:
- Defaults, iReady=1: SRA iD=0x80000000 shamt=16 -> oD=0xFFFF8000, 2 cycles after accept. SRL, same operands -> 0x00008000.
- Rotates: ROR 0x12345678 sh=8 -> 0x78123456. ROL 0x80000001 sh=1 -> 0x00000003.
- Edges: SLL 0x00000001 sh=31 -> 0x80000000. SRA 0x7FFFFFFF sh=31 -> 0 with oZero=1. Any mode with sh=0 -> iD.
- Illegal mode 6, iD=0xDEADBEEF -> oD=0xDEADBEEF, oIllegal=1, tag preserved.
- Backpressure:
  - stream 8 tagged items 0..7;
  - drop iReady for 3 cycles mid-stream;
  - oReady falls while oValid & ~iReady;
  - oD/oTag hold stable;
  - all 8 results emerge in order, none lost or duplicated;
  - check against a software reference.
- Reset: assert nRst low asynchronously (between edges) with 2 items in flight -> oValid drops immediately, outputs 0. After release, a new SLL 0x3 sh=4 -> 0x30 with no stale results.
